vai_tx_c0_arbiter: RTL and testbench
====================================

Name: vai_tx_c0_arbiter

Overview:
- Shares the single upstream CCI-P c0 Tx read-request channel among NUM_SUB_AFUS sub-AFUs.
- Accepts each AFU's read requests into a per-AFU 2-entry FIFO and selects one per cycle by round-robin.
- On issue, rewrites the request: adds that AFU's base offset to the address and stamps its vmid into mdata[15 -: VMID_WIDTH]. The Rx return path uses that vmid to demux responses.
- Bounds outstanding reads per AFU using response-return pulses from the Rx path.

Parameters:
- NUM_SUB_AFUS, 8, number of requesters; power of two, 2..16.
- VMID_WIDTH, $clog2(NUM_SUB_AFUS), vmid bits stamped into mdata.
- MAX_OUTSTANDING, 64, per-AFU in-flight read limit, 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- afu_req_valid  in  [NUM_SUB_AFUS]  per-AFU request valid
- afu_req_addr  in  [NUM_SUB_AFUS][42]  cache-line address, AFU-virtual
- afu_req_mdata  in  [NUM_SUB_AFUS][16]  AFU mdata
- afu_req_ready  out  [NUM_SUB_AFUS]  per-AFU FIFO not full
- offset_array  in  [NUM_SUB_AFUS][64]  per-AFU address offset; bits [41:0] used
- rsp_valid  in  1  one c0 read response returned upstream
- rsp_vmid  in  VMID_WIDTH  vmid of that response
- up_almfull  in  1  upstream c0 Tx almost-full
- up_req_valid  out  1  upstream request valid
- up_req_addr  out  42  translated address
- up_req_mdata  out  16  tagged mdata
- err_underflow  out  [NUM_SUB_AFUS]  sticky: response arrived with zero outstanding

Behaviour:
- Reset (reset==0 at posedge):
  - FIFOs empty; afu_req_ready all 1 on the first cycle after reset.
  - up_req_valid=0; up_req_addr and up_req_mdata = 0.
  - Outstanding counters = 0; RR pointer = 0; err_underflow = 0.
  - An in-flight issued request is dropped; counters are not reconstructed.
- Enqueue: a request is written into FIFO[i] when afu_req_valid[i] && afu_req_ready[i] at posedge. afu_req_ready[i] = (FIFO[i] count < 2), registered-free. Valid with ready low is ignored; the AFU must hold its request.
- Eligibility of AFU i: FIFO[i] non-empty && cnt[i] < MAX_OUTSTANDING.
- Stall: almfull_q is up_almfull registered once. When almfull_q==1, no grant is made.
- Arbitration, when not stalled:
  - Grant the first eligible index searching ptr, ptr+1, ... wrapping mod NUM_SUB_AFUS.
  - On grant g: pop FIFO[g]; ptr <= (g+1) mod N.
  - No eligible AFU: ptr is unchanged.
- Issue register: loaded at the grant edge.
  - up_req_valid <= grant.
  - up_req_addr <= (addr + offset_array[g][41:0]) mod 2^42. The offset is sampled at the grant cycle; later changes do not affect issued requests.
  - up_req_mdata <= {g[VMID_WIDTH-1:0], mdata[15-VMID_WIDTH:0]}. AFU-supplied top bits are overwritten.
  - With no grant, up_req_valid <= 0. Addr and mdata hold their last value.
- Latency:
  - Request accepted at edge t is eligible in cycle t+1.
  - up_req_valid is high in cycle t+2 at the earliest.
  - Sustained throughput is 1 request/cycle aggregate.
- Outstanding counter cnt[i] (8 bit):
  - Increments on grant to i.
  - Decrements on rsp_valid && rsp_vmid==i.
  - Grant and response to the same i in one cycle: unchanged.
  - Response with cnt==0: counter stays 0 and err_underflow[i] <= 1 (sticky until reset).
  - Counter never exceeds MAX_OUTSTANDING.
- FIFO simultaneous push and pop on the same AFU:
  - Count unchanged, order preserved.
  - When full (count 2), a pop in the same cycle does not raise ready combinationally. Ready rises the next cycle.

Test Plan:
- Single AFU 3, addr 0x100, mdata 0x0ABC, offset[3]=0x1000, N=8 -> two cycles after acceptance: up_req_valid=1, addr 0x1100, mdata 0x6ABC; cnt[3]=1.
- AFUs 0, 1, 5 continuously valid, no almfull -> issue order 0,1,5,0,1,5…, one per cycle, no gaps.
- Raise up_almfull with 4 queued requests -> up_req_valid goes low one cycle after almfull_q rises (≤2 cycles after up_almfull); FIFOs hold; drop almfull -> issue resumes in order.
- MAX_OUTSTANDING=2; AFU 2 issues 2 without responses -> third request stays queued and afu_req_ready[2] drops after 2 more enqueues. One rsp_valid with vmid 2 -> third issues.
- rsp_valid with vmid 4 while cnt[4]=0 -> err_underflow[4]=1 stays set; cnt[4]=0.
- Offset 0x3FF_FFFF_FFFF plus addr 0x2 -> up_req_addr 0x1 (wrap). Assert reset mid-stream -> next cycle up_req_valid=0, all ready=1, counters 0.

Source files
------------

// File: rtl/vai_tx_c0_arbiter_if.sv
// CCI-P c0 Tx read-request sharing bus: per-AFU request side, upstream
// issue side, Rx response-return pulses and per-AFU address offsets.
interface vai_tx_c0_arbiter_if #(
  parameter int NUM_SUB_AFUS = 8,
  parameter int VMID_WIDTH   = $clog2(NUM_SUB_AFUS)
);
  logic [NUM_SUB_AFUS-1:0]        afu_req_valid;
  logic [NUM_SUB_AFUS-1:0][41:0]  afu_req_addr;
  logic [NUM_SUB_AFUS-1:0][15:0]  afu_req_mdata;
  logic [NUM_SUB_AFUS-1:0]        afu_req_ready;
  logic [NUM_SUB_AFUS-1:0][63:0]  offset_array;
  logic                           rsp_valid;
  logic [VMID_WIDTH-1:0]          rsp_vmid;
  logic                           up_almfull;
  logic                           up_req_valid;
  logic [41:0]                    up_req_addr;
  logic [15:0]                    up_req_mdata;
  logic [NUM_SUB_AFUS-1:0]        err_underflow;

  // Arbiter side
  modport slave (
    input  afu_req_valid, afu_req_addr, afu_req_mdata, offset_array,
    input  rsp_valid, rsp_vmid, up_almfull,
    output afu_req_ready, up_req_valid, up_req_addr, up_req_mdata, err_underflow
  );

  // Requester / environment side
  modport master (
    output afu_req_valid, afu_req_addr, afu_req_mdata, offset_array,
    output rsp_valid, rsp_vmid, up_almfull,
    input  afu_req_ready, up_req_valid, up_req_addr, up_req_mdata, err_underflow
  );
endinterface

// File: rtl/vai_tx_c0_arbiter.sv
// Round-robin arbiter sharing the upstream c0 Tx read channel among sub-AFUs.
// Each AFU feeds a 2-entry FIFO; the winner's request is translated (base
// offset added, vmid stamped into the top mdata bits) into a registered
// upstream issue slot. Per-AFU outstanding reads are bounded using the Rx
// response-return pulses.
module vai_tx_c0_arbiter #(
  parameter int NUM_SUB_AFUS    = 8,
  parameter int VMID_WIDTH      = $clog2(NUM_SUB_AFUS),
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic               clk,
  input  logic               reset,
  vai_tx_c0_arbiter_if.slave bus
);

  localparam int              N       = NUM_SUB_AFUS;
  localparam int              IDX_W   = $clog2(NUM_SUB_AFUS);
  localparam int              MD_LO_W = 16 - VMID_WIDTH;
  localparam logic [7:0]      MAX_CNT = 8'(MAX_OUTSTANDING);

  // FIFO state: occupancy, read head and two storage slots per AFU
  logic [N-1:0][1:0]       fcnt_q;
  logic [N-1:0]            fhead_q;
  logic [N-1:0][1:0][41:0] faddr_q;
  logic [N-1:0][1:0][15:0] fmd_q;

  // Per-AFU in-flight read counters and sticky underflow flags
  logic [N-1:0][7:0]       ocnt_q;
  logic [N-1:0]            err_q;

  // Arbitration / issue state
  logic [IDX_W-1:0]        ptr_q;
  logic                    almfull_q;
  logic                    up_valid_q;
  logic [41:0]             up_addr_q;
  logic [15:0]             up_md_q;

  // Combinational decode
  logic [N-1:0]            ready;
  logic [N-1:0]            push;
  logic [N-1:0]            pop;
  logic [N-1:0]            elig;
  logic [N-1:0]            rsp_hit;
  logic [N-1:0]            wr_idx;
  logic                    gnt_vld;
  logic [IDX_W-1:0]        gnt_idx;
  logic [IDX_W-1:0]        cand;
  logic [41:0]             head_addr;
  logic [15:0]             head_md;
  logic [41:0]             gnt_addr_d;
  logic [15:0]             gnt_md_d;

  // Only the low 42 bits of each offset take part in translation
  logic                    unused_offset_hi;

  // Per-AFU FIFO handshake, eligibility and response decode
  always_comb begin
    ready   = '0;
    push    = '0;
    elig    = '0;
    rsp_hit = '0;
    wr_idx  = '0;
    for (int i = 0; i < N; i++) begin
      ready[i]   = (fcnt_q[i] != 2'd2);
      push[i]    = bus.afu_req_valid[i] && ready[i];
      elig[i]    = (fcnt_q[i] != 2'd0) && (ocnt_q[i] < MAX_CNT);
      rsp_hit[i] = bus.rsp_valid && (bus.rsp_vmid == VMID_WIDTH'(i));
      // Empty: write at head; one entry: write behind it
      wr_idx[i]  = fhead_q[i] ^ fcnt_q[i][0];
    end
  end

  // Round-robin search starting at ptr_q; index arithmetic wraps since N is 2^k
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!almfull_q) begin
      for (int k = 0; k < N; k++) begin
        cand = ptr_q + IDX_W'(k);
        if (!gnt_vld && elig[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  // Pop decode and request translation for the winner
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop[i] = gnt_vld && (gnt_idx == IDX_W'(i));
    end
    head_addr  = faddr_q[gnt_idx][fhead_q[gnt_idx]];
    head_md    = fmd_q[gnt_idx][fhead_q[gnt_idx]];
    gnt_addr_d = head_addr + bus.offset_array[gnt_idx][41:0];
    gnt_md_d   = {VMID_WIDTH'(gnt_idx), head_md[MD_LO_W-1:0]};
  end

  always_comb begin
    unused_offset_hi = 1'b0;
    for (int i = 0; i < N; i++) begin
      unused_offset_hi = unused_offset_hi ^ (^bus.offset_array[i][63:42]);
    end
  end

  // FIFO occupancy and head pointer; push+pop on one AFU keeps the count
  always_ff @(posedge clk) begin
    if (!reset) begin
      fcnt_q  <= '0;
      fhead_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (push[i] && !pop[i]) begin
          fcnt_q[i] <= fcnt_q[i] + 2'd1;
        end else if (pop[i] && !push[i]) begin
          fcnt_q[i] <= fcnt_q[i] - 2'd1;
        end
        if (pop[i]) begin
          fhead_q[i] <= ~fhead_q[i];
        end
      end
    end
  end

  // FIFO storage writes (data only, no reset needed)
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        faddr_q[i][wr_idx[i]] <= bus.afu_req_addr[i];
        fmd_q[i][wr_idx[i]]   <= bus.afu_req_mdata[i];
      end
    end
  end

  // Outstanding-read counters; a response at zero flags a sticky underflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      ocnt_q <= '0;
      err_q  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pop[i] && !rsp_hit[i]) begin
          ocnt_q[i] <= ocnt_q[i] + 8'd1;
        end else if (rsp_hit[i] && !pop[i]) begin
          if (ocnt_q[i] == 8'd0) begin
            err_q[i] <= 1'b1;
          end else begin
            ocnt_q[i] <= ocnt_q[i] - 8'd1;
          end
        end
      end
    end
  end

  // Almost-full register, RR pointer and upstream issue register
  always_ff @(posedge clk) begin
    if (!reset) begin
      almfull_q  <= 1'b0;
      ptr_q      <= '0;
      up_valid_q <= 1'b0;
      up_addr_q  <= '0;
      up_md_q    <= '0;
    end else begin
      almfull_q  <= bus.up_almfull;
      up_valid_q <= gnt_vld;
      if (gnt_vld) begin
        ptr_q     <= gnt_idx + IDX_W'(1);
        up_addr_q <= gnt_addr_d;
        up_md_q   <= gnt_md_d;
      end
    end
  end

  assign bus.afu_req_ready = ready;
  assign bus.up_req_valid  = up_valid_q;
  assign bus.up_req_addr   = up_addr_q;
  assign bus.up_req_mdata  = up_md_q;
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_vai_tx_c0_arbiter.sv
// Bench for vai_tx_c0_arbiter: table of single-request translations,
// directed multi-cycle sequences and a randomized run against a queue-based
// reference model.
module tb_vai_tx_c0_arbiter;
  localparam int N    = 8;
  localparam int VW   = 3;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vai_tx_c0_arbiter_if #(.NUM_SUB_AFUS(N), .VMID_WIDTH(VW)) ifc ();

  vai_tx_c0_arbiter #(
    .NUM_SUB_AFUS(N), .VMID_WIDTH(VW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic [41:0] a;
    logic [15:0] m;
  } req_t;

  typedef struct {
    int          afu;
    logic [41:0] addr;
    logic [15:0] md;
    logic [63:0] off;
    logic [41:0] ea;
    logic [15:0] em;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model state
  req_t        mq[N][$];
  int          outst[N];
  int          mptr;
  bit          malmq;
  logic        exp_v;
  logic [41:0] exp_a;
  logic [15:0] exp_m;
  logic [N-1:0] exp_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock: advance the model on pre-edge inputs, then compare after the edge
  task automatic step();
    logic [N-1:0] rdy;
    int g;
    req_t r;
    for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < 2);
    chk("ready", 64'(ifc.afu_req_ready), 64'(rdy));
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        mq[i].delete();
        outst[i] = 0;
      end
      mptr = 0; malmq = 0; exp_v = 0; exp_a = '0; exp_m = '0; exp_err = '0;
    end else begin
      g = -1;
      if (!malmq) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (mptr + k) % N;
          if (g < 0 && mq[idx].size() > 0 && outst[idx] < MAXO) g = idx;
        end
      end
      for (int i = 0; i < N; i++) begin
        bit dec, inc;
        dec = ifc.rsp_valid && (int'(ifc.rsp_vmid) == i);
        inc = (g == i);
        if (inc && !dec) outst[i]++;
        else if (dec && !inc) begin
          if (outst[i] == 0) exp_err[i] = 1'b1;
          else outst[i]--;
        end
      end
      if (g >= 0) begin
        r = mq[g].pop_front();
        exp_v = 1'b1;
        exp_a = r.a + ifc.offset_array[g][41:0];
        exp_m = (16'(g) << (16 - VW)) | (r.m & 16'((1 << (16 - VW)) - 1));
        mptr  = (g + 1) % N;
      end else begin
        exp_v = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (ifc.afu_req_valid[i] && rdy[i]) begin
          r.a = ifc.afu_req_addr[i];
          r.m = ifc.afu_req_mdata[i];
          mq[i].push_back(r);
        end
      end
      malmq = ifc.up_almfull;
    end
    @(posedge clk);
    #1;
    chk("up_valid", 64'(ifc.up_req_valid), 64'(exp_v));
    chk("up_addr",  64'(ifc.up_req_addr),  64'(exp_a));
    chk("up_mdata", 64'(ifc.up_req_mdata), 64'(exp_m));
    chk("err",      64'(ifc.err_underflow), 64'(exp_err));
  endtask

  task automatic do_reset();
    ifc.afu_req_valid = '0;
    ifc.rsp_valid = 1'b0;
    ifc.rsp_vmid = '0;
    ifc.up_almfull = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[5];
    int seen[$];
    int order[3];
    int nis, nacc;
    logic [N-1:0] pre_rdy, hold;

    tv[0] = '{3, 42'h100,          16'h0ABC, 64'h1000,                 42'h1100,         16'h6ABC};
    tv[1] = '{7, 42'h2,            16'hFFFF, 64'h3FF_FFFF_FFFF,        42'h1,            16'hFFFF};
    tv[2] = '{0, 42'h123,          16'hE001, 64'h0,                    42'h123,          16'h0001};
    tv[3] = '{5, 42'h3FF_FFFF_FFFF, 16'h1234, 64'h1,                   42'h0,            16'hB234};
    tv[4] = '{1, 42'h10,           16'h0000, 64'hFFFF_F000_0000_0020,  42'h30,           16'h2000};
    order[0] = 0; order[1] = 1; order[2] = 5;

    ifc.afu_req_valid = '0;
    ifc.afu_req_addr  = '0;
    ifc.afu_req_mdata = '0;
    ifc.offset_array  = '0;
    ifc.rsp_valid     = 1'b0;
    ifc.rsp_vmid      = '0;
    ifc.up_almfull    = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    chk("rst_ready", 64'(ifc.afu_req_ready), 64'hFF);
    chk("rst_valid", 64'(ifc.up_req_valid), 64'h0);
    chk("rst_addr",  64'(ifc.up_req_addr), 64'h0);
    chk("rst_mdata", 64'(ifc.up_req_mdata), 64'h0);
    chk("rst_err",   64'(ifc.err_underflow), 64'h0);

    // Table: single-request translation, two cycles after acceptance
    for (int v = 0; v < 5; v++) begin
      ifc.offset_array[tv[v].afu]  = tv[v].off;
      ifc.afu_req_addr[tv[v].afu]  = tv[v].addr;
      ifc.afu_req_mdata[tv[v].afu] = tv[v].md;
      ifc.afu_req_valid[tv[v].afu] = 1'b1;
      step();
      ifc.afu_req_valid = '0;
      step();
      chk("tv_valid", 64'(ifc.up_req_valid), 64'h1);
      chk("tv_addr",  64'(ifc.up_req_addr),  64'(tv[v].ea));
      chk("tv_mdata", 64'(ifc.up_req_mdata), 64'(tv[v].em));
      ifc.rsp_valid = 1'b1;
      ifc.rsp_vmid  = VW'(tv[v].afu);
      step();
      ifc.rsp_valid = 1'b0;
      chk("tv_no_underflow", 64'(ifc.err_underflow), 64'h0);
    end

    // Round robin among AFUs 0, 1, 5 with responses returned promptly
    do_reset();
    ifc.afu_req_valid = 8'b0010_0011;
    seen.delete();
    for (int c = 0; c < 15; c++) begin
      step();
      ifc.rsp_valid = ifc.up_req_valid;
      ifc.rsp_vmid  = ifc.up_req_mdata[15:13];
      if (ifc.up_req_valid) seen.push_back(int'(ifc.up_req_mdata[15:13]));
    end
    ifc.afu_req_valid = '0;
    ifc.rsp_valid = 1'b0;
    chk("rr_count", 64'(seen.size()), 64'd14);
    for (int k = 0; k < seen.size(); k++) chk("rr_order", 64'(seen[k]), 64'(order[k % 3]));

    // Almost-full stall and resume
    do_reset();
    for (int i = 0; i < 4; i++) ifc.afu_req_addr[i] = 42'(i * 16);
    ifc.afu_req_valid = 8'h0F;
    step();
    ifc.afu_req_valid = '0;
    ifc.up_almfull = 1'b1;
    step();
    chk("af_first", 64'(ifc.up_req_valid), 64'h1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("af_stall", 64'(ifc.up_req_valid), 64'h0);
    end
    ifc.up_almfull = 1'b0;
    step();
    chk("af_release", 64'(ifc.up_req_valid), 64'h0);
    for (int k = 1; k < 4; k++) begin
      step();
      chk("af_resume_v", 64'(ifc.up_req_valid), 64'h1);
      chk("af_resume_id", 64'(ifc.up_req_mdata[15:13]), 64'(k));
    end

    // Outstanding limit on AFU 2
    do_reset();
    ifc.offset_array[2] = 64'h500;
    ifc.afu_req_addr[2] = 42'h40;
    ifc.afu_req_valid[2] = 1'b1;
    nis = 0; nacc = 0;
    for (int c = 0; c < 6; c++) begin
      pre_rdy = ifc.afu_req_ready;
      step();
      if (pre_rdy[2]) begin
        nacc++;
        ifc.afu_req_addr[2] = 42'h40 + 42'(nacc);
      end
      if (ifc.up_req_valid) nis++;
    end
    ifc.afu_req_valid = '0;
    chk("max_issued", 64'(nis), 64'd2);
    chk("max_accepted", 64'(nacc), 64'd4);
    chk("max_ready", 64'(ifc.afu_req_ready[2]), 64'h0);
    ifc.rsp_valid = 1'b1;
    ifc.rsp_vmid  = 3'd2;
    step();
    ifc.rsp_valid = 1'b0;
    chk("max_hold", 64'(ifc.up_req_valid), 64'h0);
    step();
    chk("max_third_v", 64'(ifc.up_req_valid), 64'h1);
    chk("max_third_a", 64'(ifc.up_req_addr), 64'h542);

    // Underflow on AFU 4
    do_reset();
    ifc.rsp_valid = 1'b1;
    ifc.rsp_vmid  = 3'd4;
    step();
    ifc.rsp_valid = 1'b0;
    chk("uf_set", 64'(ifc.err_underflow), 64'h10);
    step();
    step();
    chk("uf_sticky", 64'(ifc.err_underflow), 64'h10);

    // Randomized traffic with a mid-stream reset
    do_reset();
    hold = '0;
    for (int c = 0; c < 1500; c++) begin
      reset = (c == 700) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          ifc.afu_req_valid[i] = 1'($urandom_range(0, 1));
          ifc.afu_req_addr[i]  = 42'({$urandom(), $urandom()});
          ifc.afu_req_mdata[i] = 16'($urandom());
        end
      end
      ifc.up_almfull = ($urandom_range(0, 9) == 0);
      begin
        int ri;
        ri = $urandom_range(0, N - 1);
        ifc.rsp_vmid  = VW'(ri);
        ifc.rsp_valid = (outst[ri] > 0) && ($urandom_range(0, 2) != 0);
      end
      if ($urandom_range(0, 49) == 0)
        ifc.offset_array[$urandom_range(0, N - 1)] = 64'({$urandom(), $urandom()});
      pre_rdy = ifc.afu_req_ready;
      step();
      hold = ifc.afu_req_valid & ~pre_rdy;
      if (c == 700) begin
        chk("mid_rst_ready", 64'(ifc.afu_req_ready), 64'hFF);
        chk("mid_rst_valid", 64'(ifc.up_req_valid), 64'h0);
        chk("mid_rst_err",   64'(ifc.err_underflow), 64'h0);
      end
    end
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
